// File: rtl/alu_ex_stage.sv
// Execute-stage ALU feeding a two-entry in-order output buffer (head + skid)
// with valid/ready handshakes on both sides, plus debug illegal/op counters.
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [4:0]       rd_out,
  output logic             illegal,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             in_ready_q;
  logic             in_ready_nxt;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_head_new;
  logic             load_head_skid;
  logic             load_skid;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             alu_zero;

  logic [WIDTH-1:0] skid_result;
  logic             skid_zero;
  logic [4:0]       skid_rd;
  logic             skid_illegal;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  // Illegal codes force a zero result and never flag zero.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctl)
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      default: alu_ill = 1'b1;
    endcase
    alu_zero = !alu_ill && (alu_res == '0);
  end

  always_comb begin
    state_nxt      = state;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt     = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_new = 1'b1;
        end else if (in_xfer) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt      = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    in_ready_nxt = (state_nxt != TWO);
  end

  // in_ready is registered so it never depends on out_ready in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= in_ready_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      zero         <= 1'b0;
      rd_out       <= '0;
      illegal      <= 1'b0;
      skid_result  <= '0;
      skid_zero    <= 1'b0;
      skid_rd      <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_head_new) begin
        result  <= alu_res;
        zero    <= alu_zero;
        rd_out  <= rd_in;
        illegal <= alu_ill;
      end else if (load_head_skid) begin
        result  <= skid_result;
        zero    <= skid_zero;
        rd_out  <= skid_rd;
        illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_result  <= alu_res;
        skid_zero    <= alu_zero;
        skid_rd      <= rd_in;
        skid_illegal <= alu_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count     <= '0;
      illegal_seen <= 1'b0;
    end else if (in_xfer) begin
      if (op_count != {CNT_W{1'b1}}) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (alu_ill) begin
        illegal_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomised and directed bench for alu_ex_stage, checked against a queue-based
// model of the output buffer; op_count is narrowed so saturation is reachable.
module tb_alu_ex_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [4:0]       rd;
    logic             ill;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [4:0]       rd_out;
  logic             illegal;
  logic             illegal_seen;
  logic [CNT_W-1:0] op_count;

  int tests = 0;
  int fails = 0;

  entry_t           q[$];
  entry_t           last_head;
  logic             mdl_ready;
  int               mdl_count;
  logic             mdl_seen;

  alu_ex_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .rd_out(rd_out), .illegal(illegal),
    .illegal_seen(illegal_seen), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic entry_t model_op(logic [3:0] ctl, logic [WIDTH-1:0] a,
                                      logic [WIDTH-1:0] b, logic [4:0] rd);
    entry_t e;
    e = '0;
    e.rd = rd;
    if (ctl == 4'b0010)      e.res = a + b;
    else if (ctl == 4'b0110) e.res = a - b;
    else if (ctl == 4'b0000) e.res = a & b;
    else if (ctl == 4'b0001) e.res = a | b;
    else                     e.ill = 1'b1;
    e.zero = !e.ill && (e.res == '0);
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] ctl,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [4:0] rd, input logic ordy);
    in_valid  = v;
    alu_ctl   = ctl;
    op_a      = a;
    op_b      = b;
    rd_in     = rd;
    out_ready = ordy;
  endtask

  // One clock edge: the model decides the transfers from its own state, then
  // outputs are sampled 1ns after the edge.
  task automatic tick();
    logic   acc, pop;
    entry_t e;
    acc = !rst && in_valid && mdl_ready;
    pop = !rst && (q.size() > 0) && out_ready;
    e   = model_op(alu_ctl, op_a, op_b, rd_in);
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_head = '0;
      mdl_ready = 1'b0;
      mdl_count = 0;
      mdl_seen  = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (mdl_count < (1 << CNT_W) - 1) mdl_count++;
        if (e.ill) mdl_seen = 1'b1;
      end
      if (q.size() > 0) last_head = q[0];
      mdl_ready = (q.size() <= 1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 5'd1, 1'b1);
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (result !== '0) begin fails++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    tests++; if (zero !== 1'b0 || illegal !== 1'b0 || rd_out !== 5'd0) begin fails++; $display("[TB] FAIL reset_head: zero=%b ill=%b rd=%0d want 0/0/0", zero, illegal, rd_out); end
    tests++; if (op_count !== '0 || illegal_seen !== 1'b0) begin fails++; $display("[TB] FAIL reset_debug: cnt=%0d seen=%b want 0/0", op_count, illegal_seen); end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    applyStimulus(1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
    tests++; if (result !== 32'd12) begin fails++; $display("[TB] FAIL add_result: got %h want c", result); end
    tests++; if (zero !== 1'b0 || illegal !== 1'b0 || rd_out !== 5'd3) begin fails++; $display("[TB] FAIL add_head: zero=%b ill=%b rd=%0d want 0/0/3", zero, illegal, rd_out); end
    tests++; if (op_count !== 4'd1) begin fails++; $display("[TB] FAIL add_count: got %0d want 1", op_count); end
    tick();
    tests++; if (out_valid !== 1'b0 || result !== 32'd12) begin fails++; $display("[TB] FAIL add_drain: valid=%b result=%h want 0/c", out_valid, result); end
  endtask

  task automatic test_wrap_zero();
    logic [3:0]       ctls[3] = '{4'b0110, 4'b0010, 4'b0110};
    logic [WIDTH-1:0] as[3]   = '{32'h5, 32'hFFFF_FFFF, 32'h0};
    logic [WIDTH-1:0] bs[3]   = '{32'h5, 32'h1, 32'h1};
    logic [WIDTH-1:0] rs[3]   = '{32'h0, 32'h0, 32'hFFFF_FFFF};
    logic             zs[3]   = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ctls[i], as[i], bs[i], 5'(i + 10), 1'b1);
      tick();
      tests++; if (result !== rs[i] || zero !== zs[i]) begin fails++; $display("[TB] FAIL wrap_zero_%0d: got %h/%b want %h/%b", i, result, zero, rs[i], zs[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int base;
    base = mdl_count;
    applyStimulus(1'b1, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, 1'b0);
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_one: got %b want 1", in_ready); end
    applyStimulus(1'b1, 4'b0001, 32'h1, 32'h2, 5'd5, 1'b0);
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_ready_two: got %b want 0", in_ready); end
    applyStimulus(1'b1, 4'b0010, 32'h1, 32'h1, 5'd6, 1'b0);
    tick();
    tick();
    tests++; if (op_count !== 4'(base + 2)) begin fails++; $display("[TB] FAIL bp_third_rejected: cnt=%0d want %0d", op_count, base + 2); end
    tests++; if (out_valid !== 1'b1 || result !== 32'hF000_F000 || rd_out !== 5'd4) begin fails++; $display("[TB] FAIL bp_head_stable: v=%b res=%h rd=%0d want 1/f000f000/4", out_valid, result, rd_out); end
    applyStimulus(1'b0, 4'b0010, 32'h0, 32'h0, 5'd0, 1'b1);
    tick();
    tests++; if (result !== 32'h3 || rd_out !== 5'd5 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_second_pop: v=%b res=%h rd=%0d want 1/3/5", out_valid, result, rd_out); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_return: got %b want 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ctl;
      logic [WIDTH-1:0] a, b;
      entry_t exp;
      case ($urandom_range(0, 3))
        0: ctl = 4'b0010;
        1: ctl = 4'b0110;
        2: ctl = 4'b0000;
        default: ctl = 4'b0001;
      endcase
      a = $urandom();
      b = $urandom();
      exp = model_op(ctl, a, b, 5'(i));
      applyStimulus(1'b1, ctl, a, b, 5'(i), 1'b1);
      tick();
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_flow_%0d: v=%b r=%b want 1/1", i, out_valid, in_ready); end
      tests++; if (result !== exp.res || rd_out !== exp.rd || zero !== exp.zero) begin fails++; $display("[TB] FAIL b2b_data_%0d: got %h/%0d/%b want %h/%0d/%b", i, result, rd_out, zero, exp.res, exp.rd, exp.zero); end
    end
    tests++; if (op_count !== 4'd8) begin fails++; $display("[TB] FAIL b2b_count: got %0d want 8", op_count); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    applyStimulus(1'b1, 4'b1111, 32'd9, 32'd9, 5'd7, 1'b1);
    tick();
    tests++; if (result !== '0 || illegal !== 1'b1 || zero !== 1'b0) begin fails++; $display("[TB] FAIL illegal_head: res=%h ill=%b zero=%b want 0/1/0", result, illegal, zero); end
    tests++; if (illegal_seen !== 1'b1) begin fails++; $display("[TB] FAIL illegal_seen_set: got %b want 1", illegal_seen); end
    applyStimulus(1'b1, 4'b0001, 32'd8, 32'd1, 5'd8, 1'b1);
    tick();
    tests++; if (illegal !== 1'b0 || result !== 32'd9 || illegal_seen !== 1'b1) begin fails++; $display("[TB] FAIL illegal_sticky: ill=%b res=%h seen=%b want 0/9/1", illegal, result, illegal_seen); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 4'b0010, 32'd100, 32'd1, 5'd20, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b1010, 32'd200, 32'd1, 5'd21, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL midrst_flow: v=%b r=%b want 0/0", out_valid, in_ready); end
    tests++; if (op_count !== '0 || illegal_seen !== 1'b0) begin fails++; $display("[TB] FAIL midrst_debug: cnt=%0d seen=%b want 0/0", op_count, illegal_seen); end
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_after_%0d: v=%b r=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ctl;
      logic [WIDTH-1:0] a, b;
      if ($urandom_range(0, 7) == 0) ctl = 4'($urandom_range(0, 15));
      else ctl = ($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0110;
      if ($urandom_range(0, 3) == 0) ctl = 4'b0001;
      a = $urandom();
      b = ($urandom_range(0, 4) == 0) ? a : $urandom();
      applyStimulus(1'($urandom_range(0, 1)), ctl, a, b, 5'($urandom()), 1'($urandom_range(0, 2) != 0));
      tick();
      tests++; if (out_valid !== (q.size() > 0) || in_ready !== mdl_ready) begin fails++; $display("[TB] FAIL rand_flow_%0d: v=%b r=%b want %b/%b", i, out_valid, in_ready, q.size() > 0, mdl_ready); end
      tests++; if ({result, zero, rd_out, illegal} !== last_head) begin fails++; $display("[TB] FAIL rand_head_%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", i, result, zero, rd_out, illegal, last_head.res, last_head.zero, last_head.rd, last_head.ill); end
      tests++; if (op_count !== 4'(mdl_count) || illegal_seen !== mdl_seen) begin fails++; $display("[TB] FAIL rand_debug_%0d: cnt=%0d seen=%b want %0d/%b", i, op_count, illegal_seen, mdl_count, mdl_seen); end
    end
    tests++; if (mdl_count == (1 << CNT_W) - 1 && op_count !== {CNT_W{1'b1}}) begin fails++; $display("[TB] FAIL rand_saturate: got %0d want %0d", op_count, (1 << CNT_W) - 1); end
  endtask

  initial begin
    last_head = '0;
    mdl_ready = 1'b0;
    mdl_count = 0;
    mdl_seen  = 1'b0;
    rst       = 1'b1;
    applyStimulus(1'b0, 4'b0010, '0, '0, '0, 1'b0);
    test_reset();
    test_add();
    test_wrap_zero();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands and a destination register tag.
- Computes the result and zero flag, then registers them into a 2-entry in-order output buffer (main + skid) with valid/ready handshakes on both sides.
- Feeds the memory/writeback stage.
- Keeps a sticky illegal-op flag and a saturating accepted-op counter for debug.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of op_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream has a valid op.
- in_ready  output  1  stage can accept an op this cycle.
- alu_ctl  input  4  ALU control code (0010 add, 0110 sub, 0000 and, 0001 or; all others illegal, 1111 is the decoder's invalid code).
- op_a  input  WIDTH  first operand.
- op_b  input  WIDTH  second operand.
- rd_in  input  5  destination register tag, passed through.
- out_valid  output  1  buffer head holds a valid result.
- out_ready  input  1  downstream accepts head this cycle.
- result  output  WIDTH  head result.
- zero  output  1  head result == 0 (legal ops only).
- rd_out  output  5  head destination tag.
- illegal  output  1  head op had an illegal alu_ctl.
- illegal_seen  output  1  sticky: any illegal op accepted since reset.
- op_count  output  CNT_W  number of ops accepted since reset, saturating.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, result=0, zero=0, rd_out=0, illegal=0, illegal_seen=0, op_count=0.
  - in_ready=1 from the first edge after rst deasserts.
  - While rst is high, in_ready=0 and no transfers occur on either side.
  - Reset mid-operation discards both buffer entries without producing output.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Arithmetic (computed combinationally from inputs, captured at the input transfer):
  - 0010: op_a + op_b, mod 2^WIDTH (carry dropped).
  - 0110: op_a - op_b, mod 2^WIDTH (borrow dropped).
  - 0000: op_a & op_b.
  - 0001: op_a | op_b.
  - Any other code: result=0, illegal=1, zero=0.
  - Legal codes: illegal=0, zero=(result==0).
- Latency: an op accepted at edge N is visible at the outputs (out_valid=1) after edge N if the buffer was empty. Throughput is 1 op/cycle while out_ready stays high.
- Buffer states (count of valid entries):
  - EMPTY (0): in_ready=1, out_valid=0.
    - Input transfer -> ONE.
  - ONE (1): in_ready=1, out_valid=1.
    - Input only -> TWO.
    - Output only -> EMPTY.
    - Both at the same edge -> ONE; the new op becomes head.
  - TWO (2): in_ready=0, out_valid=1.
    - Output transfer -> ONE; the skid entry moves to head in the same edge.
    - in_valid is ignored.
- in_ready is a registered output: it is 1 iff the buffer holds ≤1 entry after the current edge. It must not depend combinationally on out_ready.
- Ordering is strictly FIFO. The head outputs (result/zero/rd_out/illegal) stay stable while out_valid=1 and out_ready=0.
- When out_valid=0, head outputs hold their last values. The downstream stage must ignore them.
- op_count increments by 1 per input transfer and holds at 2^CNT_W-1 (no wrap).
- illegal_seen is set at the input transfer of an illegal op and clears only on rst.

Test Plan:
- Reset, then add: alu_ctl=0010, op_a=5, op_b=7, rd_in=3, out_ready=1 -> one edge later out_valid=1, result=12, zero=0, rd_out=3, illegal=0; op_count=1.
- Wrap and zero: sub 0x00000005-0x00000005 -> result=0, zero=1. Add 0xFFFFFFFF+1 -> result=0, zero=1. Sub 0-1 -> 0xFFFFFFFF, zero=0.
- Backpressure with out_ready=0:
  - Push and 0xF0F0F0F0,0xFF00FF00, then or 0x1,0x2 -> in_ready=0 after the second accept; a third in_valid is not accepted.
  - Raise out_ready -> 0xF000F000 is popped, then 0x3, in order; in_ready returns to 1 one edge after the first pop.
- Streaming: 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready constantly 1, op_count=8.
- Illegal code: alu_ctl=1111, op_a=9, op_b=9 -> result=0, illegal=1, zero=0, illegal_seen=1. A following legal op leaves illegal_seen=1.
- Reset mid-operation: fill TWO entries with out_ready=0, assert rst one cycle -> out_valid=0, op_count=0, illegal_seen=0. in_ready=0 during rst and 1 after it; the discarded ops never appear at the output.
